// File: rtl/msk_ct_serializer.sv
// rtl/msk_ct_serializer.sv - shared-ciphertext bus to OUT_WIDTH word stream serializer (option: MSK_SER_CLEAR_EN)
module msk_ct_serializer #(
    parameter int d         = 2,
    parameter int OUT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [128*d-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_last,
    output logic                   busy
);

    localparam int NBEATS = (128 * d) / OUT_WIDTH;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt, cnt_next;
    logic [128*d-1:0]   hreg, hreg_next;
    logic               at_last;
    logic               capture;
    logic [OUT_WIDTH-1:0] slice;

    assign at_last   = (cnt == LAST_BEAT);
    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_last  = out_valid && at_last;
    // A new block is only taken while idle or on the last-beat handshake; reset blocks capture.
    assign in_ready  = !rst && ((state == IDLE) || (out_last && out_ready));
    assign capture   = in_valid && in_ready;
    assign slice     = hreg[int'(cnt) * OUT_WIDTH +: OUT_WIDTH];

`ifdef MSK_SER_CLEAR_EN
    assign out_data = out_valid ? slice : '0;
`else
    assign out_data = slice;
`endif

    // State and beat counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Holding register; only cleared on reset when share scrubbing is enabled.
    always_ff @(posedge clk) begin
`ifdef MSK_SER_CLEAR_EN
        if (rst) begin
            hreg <= '0;
        end else begin
            hreg <= hreg_next;
        end
`else
        hreg <= hreg_next;
`endif
    end

    // Next-state logic: capture, advance on handshake, hold on stall.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hreg_next  = hreg;
        case (state)
            IDLE: begin
                if (capture) begin
                    hreg_next  = in_data;
                    cnt_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (!at_last) begin
                        cnt_next = cnt + CW'(1);
                    end else begin
                        cnt_next = '0;
                        if (capture) begin
                            hreg_next  = in_data;
                            state_next = SEND;
                        end else begin
                            state_next = IDLE;
`ifdef MSK_SER_CLEAR_EN
                            hreg_next  = '0;
`endif
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
